alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer:
// opcodes, FSM encoding and command record sizing.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_ADD     = 3'd3;
  localparam logic [2:0] OP_SUB     = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_DIV     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  // op + x + y + a_div, tag appended
  localparam int CMD_BASE_W = 27;

  function automatic int cmd_w(input int tag_w);
    return CMD_BASE_W + tag_w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command FIFO, power-of-two depth, extra level bit
// to tell full from empty.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_e;
  logic          pop_e;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign push_e = push && !full;
  assign pop_e  = pop && !empty;
  assign dout   = mem[rp];

  always_ff @(posedge clk) begin
    if (push_e) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_e) wp <= wp + 1'b1;
      if (pop_e)  rp <= rp + 1'b1;
      unique case ({push_e, pop_e})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the ALU: queues commands, drives the
// BEGIN/END handshake, returns tagged results.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63,
  parameter int TAG_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [7:0]             cmd_x,
  input  logic [7:0]             cmd_y,
  input  logic [7:0]             cmd_a_div,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   alu_resetn,
  output logic                   alu_begin,
  output logic [2:0]             alu_op,
  output logic [7:0]             alu_x,
  output logic [7:0]             alu_y,
  output logic [7:0]             alu_a_divide,
  input  logic                   alu_end,
  input  logic [15:0]            alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CW = cmd_w(TAG_W);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_n;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [CW-1:0]    din;
  logic [CW-1:0]    dout;
  logic [2:0]       op_q;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic [7:0]       a_q;
  logic [TAG_W-1:0] tag_q;
  logic [TW-1:0]    cnt;
  logic             expired;

  assign push = cmd_valid && !full;
  assign din  = {cmd_op, cmd_a_div, cmd_x, cmd_y, cmd_tag};

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign expired = (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q == OP_ILLEGAL) state_n = S_RESP;
        else                    state_n = S_START;
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (alu_end || expired) state_n = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      a_q      <= '0;
      tag_q    <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (pop) {op_q, a_q, x_q, y_q, tag_q} <= dout;
      if (state == S_START)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (state == S_LOAD && op_q == OP_ILLEGAL) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
      // END wins over a timeout landing in the same cycle
      if (state == S_WAIT) begin
        if (alu_end) begin
          rsp_data <= alu_out;
          rsp_err  <= 1'b0;
        end else if (expired) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready    = !full;
  assign alu_resetn   = !reset && (state != S_LOAD);
  assign alu_begin    = (state == S_START);
  assign alu_op       = op_q;
  assign alu_x        = x_q;
  assign alu_y        = y_q;
  assign alu_a_divide = a_q;
  assign rsp_valid    = (state == S_RESP);
  assign rsp_tag      = tag_q;
  assign busy         = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a fixed-latency
// ALU model that can be told to hang.
module tb_alu_cmd_sequencer;

  localparam int TIMEOUT = 63;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [7:0]  cmd_a_div;
  logic [3:0]  cmd_tag;
  logic        alu_resetn;
  logic        alu_begin;
  logic [2:0]  alu_op;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [7:0]  alu_a_divide;
  logic        alu_end;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_chk = 0;
  int n_bad = 0;
  int begin_cnt = 0;
  int rstn_low_cnt = 0;
  logic hang = 1'b0;
  logic armed = 1'b0;
  int dly = 0;
  logic [15:0] res = '0;

  alu_cmd_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (TIMEOUT),
    .TAG_W   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_a_div    (cmd_a_div),
    .cmd_tag      (cmd_tag),
    .alu_resetn   (alu_resetn),
    .alu_begin    (alu_begin),
    .alu_op       (alu_op),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_a_divide (alu_a_divide),
    .alu_end      (alu_end),
    .alu_out      (alu_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(
    input logic [2:0] op,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] a
  );
    logic signed [15:0] p;
    logic [15:0] q;
    logic [15:0] r;
    p = '0;
    q = '0;
    r = '0;
    case (op)
      3'd0: return {8'h00, x & y};
      3'd1: return {8'h00, x | y};
      3'd2: return {8'h00, x ^ y};
      3'd3: return {8'h00, x} + {8'h00, y};
      3'd4: return {8'h00, x} - {8'h00, y};
      3'd5: begin
        p = 16'($signed(x)) * 16'($signed(y));
        return p;
      end
      3'd6: begin
        if (y == 8'h00) return 16'hFFFF;
        q = {a, x} / {8'h00, y};
        r = {a, x} % {8'h00, y};
        return {r[7:0], q[7:0]};
      end
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: END rises LAT negedges after BEGIN, held
  // until the sequencer pulls alu_resetn low.
  always @(negedge clk) begin
    if (!alu_resetn) begin
      alu_end <= 1'b0;
      armed   <= 1'b0;
    end else if (alu_begin && !hang) begin
      armed <= 1'b1;
      dly   <= LAT;
      res   <= alu_fn(alu_op, alu_x, alu_y, alu_a_divide);
    end else if (armed) begin
      if (dly == 1) begin
        alu_end <= 1'b1;
        alu_out <= res;
        armed   <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (alu_begin) begin_cnt <= begin_cnt + 1;
    if (!alu_resetn && !reset) rstn_low_cnt <= rstn_low_cnt + 1;
  end

  task automatic check(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic send(
    input logic [2:0] op,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] a,
    input logic [3:0] tag
  );
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_a_div = a;
    cmd_tag   = tag;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("send_timeout", 0, 1);
  endtask

  task automatic get_rsp(
    input string       nm,
    input logic [15:0] d,
    input logic [3:0]  t,
    input logic        e
  );
    int i;
    i = 0;
    while (!rsp_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    check({nm, "_vld"}, 32'(rsp_valid), 1);
    check({nm, "_data"}, 32'(rsp_data), 32'(d));
    check({nm, "_tag"}, 32'(rsp_tag), 32'(t));
    check({nm, "_err"}, 32'(rsp_err), 32'(e));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_begin(output int k);
    k = 0;
    while (!alu_begin && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  logic [2:0]  t5_op  [6];
  logic [7:0]  t5_x   [6];
  logic [7:0]  t5_y   [6];
  logic [15:0] t5_exp [6];
  logic        t5_err [6];

  initial begin
    int k;
    int b0;
    int r0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_a_div = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;
    alu_out   = '0;
    alu_end   = 1'b0;

    t5_op  = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd5, 3'd7};
    t5_x   = '{8'hF0, 8'hA0, 8'h30, 8'hFF, 8'h03, 8'h12};
    t5_y   = '{8'h3C, 8'h05, 8'h10, 8'h01, 8'h04, 8'h34};
    t5_exp = '{16'h00CC, 16'h00A5, 16'h0020, 16'h0100,
               16'h000C, 16'h0000};
    t5_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_begin", 32'(alu_begin), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_resetn", 32'(alu_resetn), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", 32'(cmd_ready), 1);
    check("rel_alu_resetn", 32'(alu_resetn), 1);

    // 1: DIV 5771/135
    b0 = begin_cnt;
    send(3'd6, 8'h8B, 8'h87, 8'h16, 4'd3);
    wait_begin(k);
    check("t1_begin_lat", 32'(k), 2);
    get_rsp("t1", 16'h652A, 4'd3, 1'b0);
    check("t1_begin_cnt", 32'(begin_cnt - b0), 1);

    // 2: mixed burst
    send(3'd3, 8'h11, 8'h05, 8'h00, 4'd0);
    send(3'd5, 8'hB9, 8'h85, 8'h00, 4'd1);
    send(3'd0, 8'h11, 8'h05, 8'h00, 4'd2);
    get_rsp("t2_add", 16'h0016, 4'd0, 1'b0);
    get_rsp("t2_mul", 16'h221D, 4'd1, 1'b0);
    get_rsp("t2_and", 16'h0001, 4'd2, 1'b0);

    // 3: illegal opcode
    b0 = begin_cnt;
    send(3'd7, 8'h01, 8'h02, 8'h00, 4'd9);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t3_lat_le3", 32'(k <= 3), 1);
    get_rsp("t3", 16'h0000, 4'd9, 1'b1);
    check("t3_no_begin", 32'(begin_cnt - b0), 0);

    // 4: ALU hang then recovery
    hang = 1'b1;
    send(3'd3, 8'h01, 8'h02, 8'h00, 4'd5);
    wait_begin(k);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4_to_cycles", 32'(k), TIMEOUT + 1);
    get_rsp("t4_to", 16'h0000, 4'd5, 1'b1);
    hang = 1'b0;
    r0 = rstn_low_cnt;
    send(3'd2, 8'h0F, 8'hFF, 8'h00, 4'd6);
    get_rsp("t4_next", 16'h00F0, 4'd6, 1'b0);
    check("t4_resetn_pulse", 32'(rstn_low_cnt - r0), 1);

    // 5: back-pressure fills the FIFO
    for (int i = 0; i < 5; i++)
      send(t5_op[i], t5_x[i], t5_y[i], 8'h00, 4'(i));
    fork
      send(t5_op[5], t5_x[5], t5_y[5], 8'h00, 4'd5);
      begin
        repeat (2) @(negedge clk);
        check("t5_cmd_ready", 32'(cmd_ready), 0);
        check("t5_level", 32'(fifo_level), 4);
        for (int i = 0; i < 6; i++)
          get_rsp($sformatf("t5_%0d", i), t5_exp[i], 4'(i),
                  t5_err[i]);
      end
    join

    // 6: reset during WAIT
    hang = 1'b1;
    send(3'd3, 8'h01, 8'h01, 8'h00, 4'd1);
    send(3'd3, 8'h02, 8'h02, 8'h00, 4'd2);
    wait_begin(k);
    repeat (3) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 1);
    check("t6_level_pre", 32'(fifo_level), 1);
    reset = 1'b1;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_begin", 32'(alu_begin), 0);
    check("t6_level", 32'(fifo_level), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_alu_resetn", 32'(alu_resetn), 0);
    repeat (2) @(negedge clk);
    check("t6_alu_resetn_hold", 32'(alu_resetn), 0);
    reset = 1'b0;
    hang  = 1'b0;
    @(negedge clk);
    send(3'd6, 8'h64, 8'h07, 8'h00, 4'd7);
    get_rsp("t6_after", 16'h020E, 4'd7, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
